// File: rtl/mem_stage.sv
// Memory-access stage: forwards ALU results or performs one req/ack RAM access
// per instruction, stalling upstream while the access is outstanding.
module mem_stage #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [15:0] ex_result,
    input  logic [15:0] ex_store_data,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_reg_write,
    input  logic [3:0]  ex_dest,
    output logic        mem_stall,
    output logic        ram_req,
    output logic        ram_we,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata,
    input  logic        ram_ack,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [3:0]  wb_dest,
    output logic [15:0] wb_data,
    output logic        bus_error
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(ACK_TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        ram_req_q, ram_req_d;
    logic        ram_we_q, ram_we_d;
    logic [15:0] ram_addr_q, ram_addr_d;
    logic [15:0] ram_wdata_q, ram_wdata_d;
    logic [3:0]  dest_q, dest_d;
    logic        reg_write_q, reg_write_d;
    logic        wb_valid_q, wb_valid_d;
    logic        wb_reg_write_q, wb_reg_write_d;
    logic [3:0]  wb_dest_q, wb_dest_d;
    logic [15:0] wb_data_q, wb_data_d;
    logic        bus_error_q, bus_error_d;

    // Next-state and next-output computation for the IDLE/WAIT controller
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        ram_req_d      = ram_req_q;
        ram_we_d       = ram_we_q;
        ram_addr_d     = ram_addr_q;
        ram_wdata_d    = ram_wdata_q;
        dest_d         = dest_q;
        reg_write_d    = reg_write_q;
        wb_valid_d     = wb_valid_q;
        wb_reg_write_d = wb_reg_write_q;
        wb_dest_d      = wb_dest_q;
        wb_data_d      = wb_data_q;
        bus_error_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ex_valid) begin
                    if (ex_mem_read || ex_mem_write) begin
                        // A read+write combination is treated as a load
                        ram_addr_d  = ex_result;
                        ram_wdata_d = ex_store_data;
                        ram_we_d    = ex_mem_write & ~ex_mem_read;
                        ram_req_d   = 1'b1;
                        dest_d      = ex_dest;
                        reg_write_d = ex_reg_write;
                        cnt_d       = 8'd0;
                        wb_valid_d  = 1'b0;
                        state_d     = ST_WAIT;
                    end else begin
                        wb_valid_d     = 1'b1;
                        wb_data_d      = ex_result;
                        wb_dest_d      = ex_dest;
                        wb_reg_write_d = ex_reg_write;
                    end
                end else begin
                    wb_valid_d = 1'b0;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (ram_ack) begin
                    ram_req_d  = 1'b0;
                    state_d    = ST_IDLE;
                    wb_valid_d = 1'b1;
                    wb_dest_d  = dest_q;
                    if (ram_we_q) begin
                        wb_reg_write_d = 1'b0;
                        wb_data_d      = ram_wdata_q;
                    end else begin
                        wb_reg_write_d = reg_write_q;
                        wb_data_d      = ram_rdata;
                    end
                end else if ((cnt_q + 8'd1) == TIMEOUT_C) begin
                    ram_req_d      = 1'b0;
                    state_d        = ST_IDLE;
                    bus_error_d    = 1'b1;
                    wb_valid_d     = 1'b1;
                    wb_reg_write_d = 1'b0;
                end else begin
                    wb_valid_d = 1'b0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                ram_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= 8'd0;
            ram_req_q      <= 1'b0;
            ram_we_q       <= 1'b0;
            ram_addr_q     <= 16'd0;
            ram_wdata_q    <= 16'd0;
            dest_q         <= 4'd0;
            reg_write_q    <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_dest_q      <= 4'd0;
            wb_data_q      <= 16'd0;
            bus_error_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ram_req_q      <= ram_req_d;
            ram_we_q       <= ram_we_d;
            ram_addr_q     <= ram_addr_d;
            ram_wdata_q    <= ram_wdata_d;
            dest_q         <= dest_d;
            reg_write_q    <= reg_write_d;
            wb_valid_q     <= wb_valid_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_dest_q      <= wb_dest_d;
            wb_data_q      <= wb_data_d;
            bus_error_q    <= bus_error_d;
        end
    end

    assign mem_stall    = (state_q == ST_WAIT);
    assign ram_req      = ram_req_q;
    assign ram_we       = ram_we_q;
    assign ram_addr     = ram_addr_q;
    assign ram_wdata    = ram_wdata_q;
    assign wb_valid     = wb_valid_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_dest      = wb_dest_q;
    assign wb_data      = wb_data_q;
    assign bus_error    = bus_error_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage, built with a 4-cycle ack timeout.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [15:0] ex_result;
    logic [15:0] ex_store_data;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_reg_write;
    logic [3:0]  ex_dest;
    logic        mem_stall;
    logic        ram_req;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic        ram_ack;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [3:0]  wb_dest;
    logic [15:0] wb_data;
    logic        bus_error;

    int errors = 0;
    int checks = 0;

    mem_stage #(.ACK_TIMEOUT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_result     (ex_result),
        .ex_store_data (ex_store_data),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_reg_write  (ex_reg_write),
        .ex_dest       (ex_dest),
        .mem_stall     (mem_stall),
        .ram_req       (ram_req),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata),
        .ram_ack       (ram_ack),
        .wb_valid      (wb_valid),
        .wb_reg_write  (wb_reg_write),
        .wb_dest       (wb_dest),
        .wb_data       (wb_data),
        .bus_error     (bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},   {15'd0, ram_req},      16'd0);
        chk({tag, "_we"},    {15'd0, ram_we},       16'd0);
        chk({tag, "_addr"},  ram_addr,              16'd0);
        chk({tag, "_wdata"}, ram_wdata,             16'd0);
        chk({tag, "_wbv"},   {15'd0, wb_valid},     16'd0);
        chk({tag, "_wbrw"},  {15'd0, wb_reg_write}, 16'd0);
        chk({tag, "_wbd"},   {12'd0, wb_dest},      16'd0);
        chk({tag, "_data"},  wb_data,               16'd0);
        chk({tag, "_berr"},  {15'd0, bus_error},    16'd0);
        chk({tag, "_stall"}, {15'd0, mem_stall},    16'd0);
    endtask

    task automatic idle_inputs();
        ex_valid      = 1'b0;
        ex_result     = 16'h0000;
        ex_store_data = 16'h0000;
        ex_mem_read   = 1'b0;
        ex_mem_write  = 1'b0;
        ex_reg_write  = 1'b0;
        ex_dest       = 4'd0;
    endtask

    initial begin
        rst       = 1'b0;
        ram_ack   = 1'b0;
        ram_rdata = 16'h0000;
        idle_inputs();

        // Reset state
        tick();
        chk_all_zero("reset");
        rst = 1'b1;

        // ALU ops, one retire per cycle
        ex_valid = 1'b1; ex_result = 16'h1234; ex_dest = 4'd3; ex_reg_write = 1'b1;
        tick();
        chk("alu1_wbv",   {15'd0, wb_valid},  16'd1);
        chk("alu1_data",  wb_data,            16'h1234);
        chk("alu1_dest",  {12'd0, wb_dest},   16'd3);
        chk("alu1_stall", {15'd0, mem_stall}, 16'd0);
        ex_result = 16'h5678; ex_dest = 4'd4; ex_reg_write = 1'b0;
        tick();
        chk("alu2_wbv",  {15'd0, wb_valid},     16'd1);
        chk("alu2_data", wb_data,               16'h5678);
        chk("alu2_rw",   {15'd0, wb_reg_write}, 16'd0);
        idle_inputs();
        tick();
        chk("bubble_wbv",  {15'd0, wb_valid}, 16'd0);
        chk("bubble_hold", wb_data,           16'h5678);

        // Load acked after 3 WAIT cycles
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_result = 16'h0040; ex_dest = 4'd5; ex_reg_write = 1'b1;
        tick();
        ex_result = 16'hDEAD; ex_dest = 4'd15; ex_mem_read = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("ld_req",   {15'd0, ram_req},   16'd1);
            chk("ld_we",    {15'd0, ram_we},    16'd0);
            chk("ld_addr",  ram_addr,           16'h0040);
            chk("ld_stall", {15'd0, mem_stall}, 16'd1);
            chk("ld_wbv",   {15'd0, wb_valid},  16'd0);
            if (i == 2) begin
                ram_ack = 1'b1; ram_rdata = 16'hBEEF;
            end else begin
                ram_ack = 1'b0;
            end
            tick();
        end
        ram_ack = 1'b0;
        idle_inputs();
        chk("ld_done_req",   {15'd0, ram_req},      16'd0);
        chk("ld_done_stall", {15'd0, mem_stall},    16'd0);
        chk("ld_done_wbv",   {15'd0, wb_valid},     16'd1);
        chk("ld_done_data",  wb_data,               16'hBEEF);
        chk("ld_done_rw",    {15'd0, wb_reg_write}, 16'd1);
        chk("ld_done_dest",  {12'd0, wb_dest},      16'd5);

        // Store acked after 1 cycle
        ex_valid = 1'b1; ex_mem_write = 1'b1; ex_result = 16'h0010; ex_store_data = 16'h00AA;
        ex_dest = 4'd6; ex_reg_write = 1'b1;
        tick();
        chk("st_req",   {15'd0, ram_req}, 16'd1);
        chk("st_we",    {15'd0, ram_we},  16'd1);
        chk("st_addr",  ram_addr,         16'h0010);
        chk("st_wdata", ram_wdata,        16'h00AA);
        idle_inputs();
        ram_ack = 1'b1; ram_rdata = 16'h7777;
        tick();
        ram_ack = 1'b0;
        chk("st_done_req",  {15'd0, ram_req},      16'd0);
        chk("st_done_wbv",  {15'd0, wb_valid},     16'd1);
        chk("st_done_rw",   {15'd0, wb_reg_write}, 16'd0);
        chk("st_done_data", wb_data,               16'h00AA);
        chk("st_done_dest", {12'd0, wb_dest},      16'd6);

        // Load with no ack: abort after 4 cycles
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_result = 16'h0080; ex_dest = 4'd7; ex_reg_write = 1'b1;
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            chk("to_req",  {15'd0, ram_req},   16'd1);
            chk("to_berr", {15'd0, bus_error}, 16'd0);
            tick();
        end
        chk("to_req_last", {15'd0, ram_req}, 16'd1);
        // Next instruction presented in the abort cycle
        ex_valid = 1'b1; ex_result = 16'h0099; ex_dest = 4'd2; ex_reg_write = 1'b1;
        tick();
        chk("to_req_drop", {15'd0, ram_req},      16'd0);
        chk("to_berr_hi",  {15'd0, bus_error},    16'd1);
        chk("to_wbv",      {15'd0, wb_valid},     16'd1);
        chk("to_rw",       {15'd0, wb_reg_write}, 16'd0);
        chk("to_stall",    {15'd0, mem_stall},    16'd0);
        tick();
        idle_inputs();
        chk("to_next_berr", {15'd0, bus_error}, 16'd0);
        chk("to_next_wbv",  {15'd0, wb_valid},  16'd1);
        chk("to_next_data", wb_data,            16'h0099);

        // Ack on the same edge as the timeout: ack wins
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_result = 16'h00C0; ex_dest = 4'd8; ex_reg_write = 1'b1;
        tick();
        idle_inputs();
        tick(); tick(); tick();
        chk("co_req", {15'd0, ram_req}, 16'd1);
        ram_ack = 1'b1; ram_rdata = 16'hCAFE;
        tick();
        ram_ack = 1'b0;
        chk("co_wbv",  {15'd0, wb_valid},     16'd1);
        chk("co_rw",   {15'd0, wb_reg_write}, 16'd1);
        chk("co_data", wb_data,               16'hCAFE);
        chk("co_berr", {15'd0, bus_error},    16'd0);
        tick();
        chk("co_after_berr", {15'd0, bus_error}, 16'd0);
        chk("co_after_wbv",  {15'd0, wb_valid},  16'd0);

        // Reset during WAIT, then a stray ack in IDLE
        ex_valid = 1'b1; ex_mem_write = 1'b1; ex_result = 16'h0100; ex_store_data = 16'h0055; ex_dest = 4'd9;
        tick();
        chk("rw_req", {15'd0, ram_req}, 16'd1);
        idle_inputs();
        rst = 1'b0;
        tick();
        chk_all_zero("rst_wait");
        rst = 1'b1;
        ram_ack = 1'b1; ram_rdata = 16'h1111;
        tick();
        ram_ack = 1'b0;
        chk("stray_wbv",   {15'd0, wb_valid},  16'd0);
        chk("stray_stall", {15'd0, mem_stall}, 16'd0);
        chk("stray_data",  wb_data,            16'h0000);
        tick();
        chk_all_zero("stray_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
